// File: rtl/cpu_forward_hazard.sv
// cpu_forward_hazard
// Operand forwarding and hazard detection between decode and execute.
// Each decode source picks the youngest matching producer stage, falls back to
// the register file otherwise, and reports load-use or out-of-window hazards.
// A per-register in-flight scoreboard covers producers that have left the
// forwarding window. Stall bookkeeping: total stall cycles, a watchdog for
// long consecutive stalls, and a sticky scoreboard error flag.
//
// Ports:
//   i_clock, i_reset         clock, synchronous active-high reset
//   i_dec_valid              decode holds a valid instruction
//   i_dec_have_rs/inst_rs    per-source use flag and register index (5 bits each)
//   i_rf_rs                  register-file read values per source
//   i_stg_valid/inst_rd/rd   producer stages (0 = youngest): valid, dest, value
//   i_stg_rd_ready           stage value is final
//   i_issue/_has_rd/_rd      instruction issued to execute this cycle
//   i_retire/_rd             writeback commit this cycle
//   o_rs                     forwarded operands
//   o_stall                  decode must hold (combinational)
//   o_stall_count            total stall cycles since reset
//   o_deadlock               consecutive stalls exceeded STALL_LIMIT
//   o_sb_error               sticky scoreboard overflow/underflow/protocol error
module cpu_forward_hazard #(
  parameter int XLEN        = 32,
  parameter int NUM_RS      = 3,
  parameter int NUM_STAGES  = 3,
  parameter int CNT_W       = 2,
  parameter int STALL_LIMIT = 1023
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_dec_valid,
  input  logic [NUM_RS-1:0]            i_dec_have_rs,
  input  logic [NUM_RS*5-1:0]          i_dec_inst_rs,
  input  logic [NUM_RS*XLEN-1:0]       i_rf_rs,
  input  logic [NUM_STAGES-1:0]        i_stg_valid,
  input  logic [NUM_STAGES*5-1:0]      i_stg_inst_rd,
  input  logic [NUM_STAGES*XLEN-1:0]   i_stg_rd,
  input  logic [NUM_STAGES-1:0]        i_stg_rd_ready,
  input  logic                         i_issue,
  input  logic                         i_issue_has_rd,
  input  logic [4:0]                   i_issue_rd,
  input  logic                         i_retire,
  input  logic [4:0]                   i_retire_rd,
  output logic [NUM_RS*XLEN-1:0]       o_rs,
  output logic                         o_stall,
  output logic [31:0]                  o_stall_count,
  output logic                         o_deadlock,
  output logic                         o_sb_error
);

  // Run counter saturates at STALL_LIMIT+1, so it needs room for that value.
  localparam int RUN_W = $clog2(STALL_LIMIT + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

  state_t             state_r, state_nxt_s;
  logic [RUN_W-1:0]   run_cnt_r, run_nxt_s;
  logic               deadlock_r;
  logic [31:0]        stall_count_r;
  logic               sb_error_r;
  logic [CNT_W-1:0]   sb_cnt_r [1:31];
  logic [CNT_W-1:0]   sb_nxt_s [1:31];
  logic               sb_err_set_s;
  logic [31:0]        sb_busy_s;
  logic [NUM_RS-1:0]  hazard_s;
  logic               stall_s;
  logic               issue_ok_s;
  logic               retire_ok_s;

  // Per-register "in flight" flags; x0 is never busy.
  always_comb begin
    sb_busy_s = 32'd0;
    for (int r = 1; r < 32; r++) begin
      sb_busy_s[r] = |sb_cnt_r[r];
    end
  end

  // Operand selection and hazard detection per source.
  always_comb begin
    logic [4:0]      idx;
    logic            hit;
    logic            hit_rdy;
    logic [XLEN-1:0] hit_val;
    logic            match;
    o_rs     = '0;
    hazard_s = '0;
    idx      = 5'd0;
    hit      = 1'b0;
    hit_rdy  = 1'b1;
    hit_val  = '0;
    match    = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      idx     = i_dec_inst_rs[5*k +: 5];
      hit     = 1'b0;
      hit_rdy = 1'b1;
      hit_val = '0;
      // Walk oldest to youngest so the youngest match overwrites the rest.
      for (int s = NUM_STAGES - 1; s >= 0; s--) begin
        match   = i_stg_valid[s] && (i_stg_inst_rd[5*s +: 5] == idx);
        hit     = hit | match;
        hit_val = match ? i_stg_rd[XLEN*s +: XLEN] : hit_val;
        hit_rdy = match ? i_stg_rd_ready[s] : hit_rdy;
      end
      if (!i_dec_have_rs[k] || (idx == 5'd0)) begin
        o_rs[XLEN*k +: XLEN] = '0;
        hazard_s[k]          = 1'b0;
      end else if (hit) begin
        o_rs[XLEN*k +: XLEN] = hit_val;
        hazard_s[k]          = !hit_rdy;
      end else begin
        o_rs[XLEN*k +: XLEN] = i_rf_rs[XLEN*k +: XLEN];
        hazard_s[k]          = sb_busy_s[idx];
      end
    end
  end

  assign stall_s     = i_dec_valid && (|hazard_s);
  // An issue while stalled is a protocol violation and is not counted.
  assign issue_ok_s  = i_issue && !stall_s && i_issue_has_rd && (i_issue_rd != 5'd0);
  assign retire_ok_s = i_retire && (i_retire_rd != 5'd0);

  // Scoreboard next state with saturation and error detection.
  always_comb begin
    logic inc;
    logic dec;
    sb_err_set_s = i_issue && stall_s;
    inc          = 1'b0;
    dec          = 1'b0;
    for (int r = 1; r < 32; r++) begin
      sb_nxt_s[r] = sb_cnt_r[r];
      inc         = issue_ok_s && (i_issue_rd == 5'(r));
      dec         = retire_ok_s && (i_retire_rd == 5'(r));
      if (inc && !dec) begin
        if (sb_cnt_r[r] == CNT_MAX) begin
          sb_err_set_s = 1'b1;
        end else begin
          sb_nxt_s[r] = sb_cnt_r[r] + CNT_W'(1);
        end
      end else if (dec && !inc) begin
        if (sb_cnt_r[r] == '0) begin
          sb_err_set_s = 1'b1;
        end else begin
          sb_nxt_s[r] = sb_cnt_r[r] - CNT_W'(1);
        end
      end else begin
        sb_nxt_s[r] = sb_cnt_r[r];
      end
    end
  end

  // Stall FSM next state and consecutive-stall counter.
  always_comb begin
    state_nxt_s = state_r;
    run_nxt_s   = '0;
    case (state_r)
      ST_RUN: begin
        if (stall_s) begin
          state_nxt_s = ST_STALL;
          run_nxt_s   = RUN_W'(1);
        end else begin
          state_nxt_s = ST_RUN;
          run_nxt_s   = '0;
        end
      end
      ST_STALL: begin
        if (stall_s) begin
          state_nxt_s = ST_STALL;
          run_nxt_s   = (run_cnt_r == RUN_MAX) ? RUN_MAX : run_cnt_r + RUN_W'(1);
        end else begin
          state_nxt_s = ST_RUN;
          run_nxt_s   = '0;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        run_nxt_s   = '0;
      end
    endcase
  end

  // State, counters, scoreboard and sticky error registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r       <= ST_RUN;
      run_cnt_r     <= '0;
      deadlock_r    <= 1'b0;
      stall_count_r <= 32'd0;
      sb_error_r    <= 1'b0;
      for (int r = 1; r < 32; r++) begin
        sb_cnt_r[r] <= '0;
      end
    end else begin
      state_r       <= state_nxt_s;
      run_cnt_r     <= run_nxt_s;
      deadlock_r    <= (run_nxt_s > RUN_LIM);
      stall_count_r <= stall_count_r + 32'(stall_s);
      sb_error_r    <= sb_error_r | sb_err_set_s;
      for (int r = 1; r < 32; r++) begin
        sb_cnt_r[r] <= sb_nxt_s[r];
      end
    end
  end

  assign o_stall       = stall_s;
  assign o_stall_count = stall_count_r;
  assign o_deadlock    = deadlock_r;
  assign o_sb_error    = sb_error_r;

endmodule

// File: tb/tb_cpu_forward_hazard.sv
// Testbench for cpu_forward_hazard: directed scenarios followed by random
// stimulus, compared against a behavioural model of the forwarding rules.
module tb_cpu_forward_hazard;

  localparam int XLEN  = 32;
  localparam int NRS   = 3;
  localparam int NST   = 3;
  localparam int LIMIT = 4;
  localparam int CMAX  = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 dec_valid;
  logic [NRS-1:0]       dec_have_rs;
  logic [NRS*5-1:0]     dec_inst_rs;
  logic [NRS*XLEN-1:0]  rf_rs;
  logic [NST-1:0]       stg_valid;
  logic [NST*5-1:0]     stg_inst_rd;
  logic [NST*XLEN-1:0]  stg_rd;
  logic [NST-1:0]       stg_rd_ready;
  logic                 issue, issue_has_rd, retire;
  logic [4:0]           issue_rd, retire_rd;
  logic [NRS*XLEN-1:0]  o_rs;
  logic                 o_stall, o_deadlock, o_sb_error;
  logic [31:0]          o_stall_count;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int          sb [32];
  logic [31:0] m_count;
  int          m_consec;
  logic        m_dead, m_err;

  always #5 clk = ~clk;

  cpu_forward_hazard #(
    .XLEN(XLEN), .NUM_RS(NRS), .NUM_STAGES(NST), .CNT_W(2), .STALL_LIMIT(LIMIT)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_dec_valid(dec_valid),
    .i_dec_have_rs(dec_have_rs), .i_dec_inst_rs(dec_inst_rs), .i_rf_rs(rf_rs),
    .i_stg_valid(stg_valid), .i_stg_inst_rd(stg_inst_rd), .i_stg_rd(stg_rd),
    .i_stg_rd_ready(stg_rd_ready), .i_issue(issue), .i_issue_has_rd(issue_has_rd),
    .i_issue_rd(issue_rd), .i_retire(retire), .i_retire_rd(retire_rd),
    .o_rs(o_rs), .o_stall(o_stall), .o_stall_count(o_stall_count),
    .o_deadlock(o_deadlock), .o_sb_error(o_sb_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    dec_valid = 1'b0; dec_have_rs = '0; dec_inst_rs = '0; rf_rs = '0;
    stg_valid = '0; stg_inst_rd = '0; stg_rd = '0; stg_rd_ready = '1;
    issue = 1'b0; issue_has_rd = 1'b0; issue_rd = 5'd0;
    retire = 1'b0; retire_rd = 5'd0;
  endtask

  task automatic set_src(input int k, input logic h, input logic [4:0] idx, input logic [31:0] v);
    dec_have_rs[k]         = h;
    dec_inst_rs[5*k +: 5]  = idx;
    rf_rs[XLEN*k +: XLEN]  = v;
  endtask

  task automatic set_stg(input int s, input logic vld, input logic [4:0] rd,
                         input logic [31:0] v, input logic rdy);
    stg_valid[s]             = vld;
    stg_inst_rd[5*s +: 5]    = rd;
    stg_rd[XLEN*s +: XLEN]   = v;
    stg_rd_ready[s]          = rdy;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) sb[r] = 0;
    m_count = 32'd0; m_consec = 0; m_dead = 1'b0; m_err = 1'b0;
  endtask

  // Expected operands and stall from the current inputs and model scoreboard.
  task automatic model_comb(output logic [31:0] rs_e [NRS], output logic st);
    logic [4:0] idx;
    int win;
    logic haz;
    haz = 1'b0;
    for (int k = 0; k < NRS; k++) begin
      idx = dec_inst_rs[5*k +: 5];
      rs_e[k] = 32'd0;
      if (dec_have_rs[k] && idx != 5'd0) begin
        win = -1;
        for (int s = 0; s < NST; s++)
          if (win < 0 && stg_valid[s] && stg_inst_rd[5*s +: 5] == idx) win = s;
        if (win >= 0) begin
          rs_e[k] = stg_rd[XLEN*win +: XLEN];
          if (!stg_rd_ready[win]) haz = 1'b1;
        end else begin
          rs_e[k] = rf_rs[XLEN*k +: XLEN];
          if (sb[idx] != 0) haz = 1'b1;
        end
      end
    end
    st = dec_valid && haz;
  endtask

  // Model state update for one clock edge.
  task automatic model_edge(input logic st);
    int inc, dec;
    if (rst) begin
      model_reset();
    end else begin
      if (st) m_count = m_count + 32'd1;
      m_consec = st ? ((m_consec + 1 > LIMIT + 1) ? LIMIT + 1 : m_consec + 1) : 0;
      m_dead = (m_consec > LIMIT);
      if (issue && st) m_err = 1'b1;
      inc = (issue && !st && issue_has_rd && issue_rd != 5'd0) ? int'(issue_rd) : 0;
      dec = (retire && retire_rd != 5'd0) ? int'(retire_rd) : 0;
      if (!(inc != 0 && inc == dec)) begin
        if (inc != 0) begin
          if (sb[inc] == CMAX) m_err = 1'b1; else sb[inc]++;
        end
        if (dec != 0) begin
          if (sb[dec] == 0) m_err = 1'b1; else sb[dec]--;
        end
      end
    end
  endtask

  // One cycle: check combinational outputs, clock, check registered outputs.
  task automatic tick(input string tag);
    logic [31:0] rs_e [NRS];
    logic st;
    #1;
    model_comb(rs_e, st);
    for (int k = 0; k < NRS; k++)
      check($sformatf("%s_rs%0d", tag, k), o_rs[XLEN*k +: XLEN], rs_e[k]);
    check({tag, "_stall"}, {31'd0, o_stall}, {31'd0, st});
    model_edge(st);
    @(posedge clk);
    #1;
    check({tag, "_count"}, o_stall_count, m_count);
    check({tag, "_dead"}, {31'd0, o_deadlock}, {31'd0, m_dead});
    check({tag, "_sberr"}, {31'd0, o_sb_error}, {31'd0, m_err});
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    tick("reset");
    rst = 1'b0;
    check("reset_count", o_stall_count, 32'd0);
    check("reset_dead", {31'd0, o_deadlock}, 32'd0);

    // youngest stage wins
    set_stg(0, 1'b1, 5'd5, 32'hAAAA, 1'b1);
    set_stg(2, 1'b1, 5'd5, 32'hBBBB, 1'b1);
    set_src(0, 1'b1, 5'd5, 32'h1111);
    dec_valid = 1'b1;
    #1;
    check("youngest_rs0", o_rs[31:0], 32'hAAAA);
    check("youngest_stall", {31'd0, o_stall}, 32'd0);
    tick("youngest");

    // x0 never forwarded
    clear_inputs();
    set_stg(1, 1'b1, 5'd0, 32'h1234, 1'b1);
    set_src(1, 1'b1, 5'd0, 32'h5555);
    dec_valid = 1'b1;
    #1;
    check("x0_rs1", o_rs[63:32], 32'd0);
    tick("x0");

    // load-use stall for two cycles
    clear_inputs();
    rst = 1'b1; tick("rst_lu"); rst = 1'b0;
    set_stg(0, 1'b1, 5'd7, 32'h77, 1'b0);
    set_src(0, 1'b1, 5'd7, 32'h0);
    dec_valid = 1'b1;
    #1; check("lu_stall1", {31'd0, o_stall}, 32'd1);
    tick("lu1");
    #1; check("lu_stall2", {31'd0, o_stall}, 32'd1);
    tick("lu2");
    stg_rd_ready[0] = 1'b1;
    #1; check("lu_stall3", {31'd0, o_stall}, 32'd0);
    check("lu_rs0", o_rs[31:0], 32'h77);
    tick("lu3");
    check("lu_count", o_stall_count, 32'd2);

    // out-of-window producer tracked by scoreboard
    clear_inputs();
    issue = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd9;
    tick("sb_issue");
    clear_inputs();
    set_src(0, 1'b1, 5'd9, 32'h99);
    dec_valid = 1'b1;
    #1; check("oow_stall", {31'd0, o_stall}, 32'd1);
    tick("oow1");
    tick("oow2");
    retire = 1'b1; retire_rd = 5'd9;
    #1; check("oow_retire_stall", {31'd0, o_stall}, 32'd1);
    tick("oow_ret");
    retire = 1'b0; retire_rd = 5'd0;
    #1; check("oow_clear", {31'd0, o_stall}, 32'd0);
    check("oow_rs0", o_rs[31:0], 32'h99);
    tick("oow_done");

    // simultaneous issue/retire, underflow error
    clear_inputs();
    rst = 1'b1; tick("rst_sb"); rst = 1'b0;
    issue = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd3;
    tick("sb3_inc");
    retire = 1'b1; retire_rd = 5'd3;
    tick("sb3_same");
    clear_inputs();
    set_src(2, 1'b1, 5'd3, 32'h3);
    dec_valid = 1'b1;
    #1; check("sb3_still_busy", {31'd0, o_stall}, 32'd1);
    tick("sb3_chk");
    clear_inputs();
    retire = 1'b1; retire_rd = 5'd4;
    tick("under");
    check("under_err", {31'd0, o_sb_error}, 32'd1);
    clear_inputs();
    tick("sticky1");
    tick("sticky2");
    check("sticky_err", {31'd0, o_sb_error}, 32'd1);
    rst = 1'b1; tick("rst_err"); rst = 1'b0;
    check("err_cleared", {31'd0, o_sb_error}, 32'd0);

    // deadlock watchdog
    set_stg(0, 1'b1, 5'd7, 32'h7, 1'b0);
    set_src(0, 1'b1, 5'd7, 32'h0);
    dec_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick($sformatf("dl%0d", i));
      check($sformatf("dl_lit%0d", i), {31'd0, o_deadlock}, {31'd0, (i >= 5)});
    end
    dec_valid = 1'b0;
    tick("dl_off");
    check("dl_cleared", {31'd0, o_deadlock}, 32'd0);
    dec_valid = 1'b1;
    tick("dl_re1");
    tick("dl_re2");
    rst = 1'b1;
    tick("dl_rst");
    rst = 1'b0;
    check("midrst_count", o_stall_count, 32'd0);
    check("midrst_dead", {31'd0, o_deadlock}, 32'd0);
    clear_inputs();
    tick("post_rst");

    // random stimulus against the model
    for (int c = 0; c < 400; c++) begin
      rst = (c % 60 == 59);
      dec_valid = 1'($urandom_range(0, 3) != 0);
      for (int k = 0; k < NRS; k++)
        set_src(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      for (int s = 0; s < NST; s++)
        set_stg(s, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 3) != 0));
      issue = 1'($urandom_range(0, 2) == 0);
      issue_has_rd = 1'($urandom_range(0, 3) != 0);
      issue_rd = 5'($urandom_range(0, 9));
      retire = 1'($urandom_range(0, 2) == 0);
      retire_rd = 5'($urandom_range(0, 9));
      tick("rand");
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_forward_hazard.md
Name: cpu_forward_hazard

Overview:
Parametrised operand-forwarding and hazard unit sitting between decode and execute. It generalises the fixed three-source, three-stage forwarder to NUM_RS sources and NUM_STAGES producer stages. It adds the following behaviour the fixed forwarder lacks:
- x0 exclusion from forwarding.
- Per-stage value-ready qualification, giving load-use stall.
- A per-register in-flight scoreboard for producers outside the forwarding window.
- Stall bookkeeping: stall-cycle counter, deadlock watchdog and sticky scoreboard error.

Parameters:
XLEN, 32, operand/result width
NUM_RS, 3, number of source operands per instruction
NUM_STAGES, 3, number of forwarding producer stages; index 0 = youngest (execute)
CNT_W, 2, width of per-register in-flight counter
STALL_LIMIT, 1023, consecutive stall cycles before o_deadlock asserts

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_dec_valid  in  1  decode holds a valid instruction
i_dec_have_rs  in  NUM_RS  source k used
i_dec_inst_rs  in  NUM_RS*5  source register indices, k at [5k+4:5k]
i_rf_rs  in  NUM_RS*XLEN  register-file read values
i_stg_valid  in  NUM_STAGES  stage s holds a valid writing instruction
i_stg_inst_rd  in  NUM_STAGES*5  stage destination index
i_stg_rd  in  NUM_STAGES*XLEN  stage result value
i_stg_rd_ready  in  NUM_STAGES  stage result final (0 = load/long op pending)
i_issue  in  1  decode instruction accepted into execute this cycle
i_issue_has_rd  in  1  issued instruction writes rd
i_issue_rd  in  5  issued destination
i_retire  in  1  writeback commits a register write this cycle
i_retire_rd  in  5  committed destination
o_rs  out  NUM_RS*XLEN  forwarded operands
o_stall  out  1  decode must hold
o_stall_count  out  32  total stall cycles since reset
o_deadlock  out  1  consecutive stalls > STALL_LIMIT
o_sb_error  out  1  sticky scoreboard overflow/underflow

Behaviour:
- Forwarding is combinational, 0-cycle latency.
- Per source k:
  - If have_rs[k]=0: o_rs[k]=0.
  - Else if inst_rs[k]==0: o_rs[k]=0. x0 is never forwarded, even if a stage has rd=0.
  - Else use the lowest s with stg_valid[s] && stg_inst_rd[s]==inst_rs[k]: o_rs[k]=stg_rd[s]. Youngest wins.
  - Else o_rs[k]=i_rf_rs[k].
- Hazards per used, nonzero source k:
  - Load-use: the winning stage has rd_ready=0.
  - Out-of-window: no stage matches and sb_cnt[inst_rs[k]] != 0.
- o_stall = i_dec_valid && (any hazard). Combinational.
- Scoreboard:
  - 31 counters sb_cnt[1..31], CNT_W bits each; x0 is never tracked.
  - On clock edge: increment on i_issue&&has_rd&&rd!=0, decrement on i_retire&&retire_rd!=0.
  - Simultaneous issue and retire of the same reg: no change.
  - Increment at max: saturate and set o_sb_error.
  - Decrement at 0: stay 0 and set o_sb_error.
  - o_sb_error clears only on reset.
- Issue is ignored (not counted) if i_issue && o_stall. This is a protocol violation and also sets o_sb_error.
- Stall FSM, states RUN and STALL:
  - RUN→STALL when o_stall=1. STALL→RUN when o_stall=0.
  - Consecutive counter run_cnt: cleared in RUN, +1 per STALL cycle, saturating at STALL_LIMIT+1.
  - o_deadlock = registered (run_cnt > STALL_LIMIT); clears the cycle after leaving STALL.
- o_stall_count: +1 each cycle o_stall=1, wraps at 2^32.
- Reset: all sb_cnt=0, FSM=RUN, run_cnt=0, o_stall_count=0, o_deadlock=0, o_sb_error=0. Reset mid-stall discards everything. Combinational outputs follow inputs with an empty scoreboard.

Test Plan:
- Stage0 rd=5 val 0xAAAA, stage2 rd=5 val 0xBBBB, rs1=5 → o_rs[0]=0xAAAA, no stall.
- Stage1 valid rd=0 val 0x1234, rs2=0 have_rs=1 → o_rs[1]=0.
- Stage0 rd=7 ready=0, rs1=7, dec_valid=1 for 2 cycles then ready=1 → o_stall=1,1,0; o_stall_count=2.
- Issue rd=9; no stage holds 9; decode rs1=9 → stall until retire rd=9. After the next edge sb_cnt[9]=0 and o_stall=0.
- Issue+retire rd=3 same cycle with count 1 → count stays 1. Retire rd=4 at 0 → o_sb_error=1, sticky until reset.
- STALL_LIMIT=4, hold hazard 6 cycles → o_deadlock rises after the 5th stall cycle. Hazard removed → o_deadlock=0 next cycle. Reset mid-stall → all counters 0.
